// File: rtl/pll_pkg.sv
// Shared types, default widths/gains and saturating arithmetic for the PLL
// digital loop filter.
package pll_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      UPDATE,
      DRAIN
   } lf_state_t;

   localparam int CTRL_W    = 10;
   localparam int CNT_W     = 8;
   localparam int CTRL_INIT = 512;
   localparam int KP_SHIFT  = 1;
   localparam int KI_SHIFT  = 3;

   // Symmetric saturating add: result clamped to [-lim, +lim].
   function automatic int sat_add(input int a, input int b, input int lim);
      int s;
      s = a + b;
      if (s > lim)
         return lim;
      if (s < -lim)
         return -lim;
      return s;
   endfunction

endpackage

// File: rtl/lf_sync.sv
// Two-flop synchronizer for the asynchronous PFD pulses, cleared by fv_rst.
module lf_sync (
   input  logic clk,
   input  logic fv_rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops sample
   // the pre-edge values; the reset branch is asynchronous via the sensitivity list.
   always_ff @(posedge clk or posedge fv_rst) begin
      if (fv_rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pfd_loop_filter.sv
// PFD pulse-width measurement plus PI loop filter producing a clamped DCO word.
// Optional lock detector enabled by defining LF_LOCK_DET_EN.
module pfd_loop_filter #(
   parameter int CTRL_W    = pll_pkg::CTRL_W,
   parameter int CNT_W     = pll_pkg::CNT_W,
   parameter int CTRL_INIT = pll_pkg::CTRL_INIT,
   parameter int KP_SHIFT  = pll_pkg::KP_SHIFT,
   parameter int KI_SHIFT  = pll_pkg::KI_SHIFT,
   parameter int LOCK_TOL  = 2,
   parameter int LOCK_CNT  = 4
) (
   input  logic              clk,
   input  logic              fv_rst,
   input  logic              up,
   input  logic              dn,
   output logic [CTRL_W-1:0] ctrl,
   output logic              ctrl_valid,
   output logic              locked
);
   import pll_pkg::*;

   localparam int IW       = CTRL_W + KI_SHIFT + 1;
   localparam int ERR_LIM  = 2**(CNT_W-1) - 1;
   localparam int INT_LIM  = 2**(IW-1) - 1;
   localparam int CTRL_MAX = 2**CTRL_W - 1;
   localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(2**CNT_W - 2);

   logic up_s, dn_s;

   lf_sync u_sync_up (.clk(clk), .fv_rst(fv_rst), .d(up), .q(up_s));
   lf_sync u_sync_dn (.clk(clk), .fv_rst(fv_rst), .d(dn), .q(dn_s));

   lf_state_t               state, state_nxt;
   logic signed [CNT_W-1:0] err;
   logic        [CNT_W-1:0] dur;
   logic signed [IW-1:0]    integ, integ_nxt;
   logic                    tmo, tmo_set, count_en;
   int                      step, ctrl_sum;
   logic        [CTRL_W-1:0] ctrl_nxt;

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      count_en  = 1'b0;
      tmo_set   = 1'b0;
      step      = 0;
      if (up_s && !dn_s)
         step = 1;
      else if (dn_s && !up_s)
         step = -1;

      case (state)
         IDLE: begin
            if (up_s || dn_s) begin
               state_nxt = MEASURE;
               count_en  = 1'b1;
            end
         end
         MEASURE: begin
            count_en = 1'b1;
            if (!up_s && !dn_s) begin
               state_nxt = UPDATE;
            end else if (dur == DUR_LAST) begin
               // This cycle brings dur to all-ones: pulse too long, give up on it.
               state_nxt = UPDATE;
               tmo_set   = 1'b1;
            end
         end
         UPDATE:  state_nxt = tmo ? DRAIN : IDLE;
         DRAIN: begin
            if (!up_s && !dn_s)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // PI update: integrator first, then proportional term on the raw error.
   always_comb begin
      integ_nxt = IW'(sat_add(int'(integ), int'(err), INT_LIM));
      ctrl_sum  = CTRL_INIT + (int'(integ_nxt) >>> KI_SHIFT) + (int'(err) >>> KP_SHIFT);
      if (ctrl_sum < 0)
         ctrl_nxt = '0;
      else if (ctrl_sum > CTRL_MAX)
         ctrl_nxt = CTRL_W'(CTRL_MAX);
      else
         ctrl_nxt = CTRL_W'(ctrl_sum);
   end

   always_ff @(posedge clk or posedge fv_rst) begin
      if (fv_rst) begin
         state      <= IDLE;
         err        <= '0;
         dur        <= '0;
         integ      <= '0;
         tmo        <= 1'b0;
         ctrl       <= CTRL_W'(CTRL_INIT);
         ctrl_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         ctrl_valid <= (state == UPDATE);
         if (state == UPDATE) begin
            err   <= '0;
            dur   <= '0;
            integ <= integ_nxt;
            ctrl  <= ctrl_nxt;
            tmo   <= 1'b0;
         end else if (count_en) begin
            err <= CNT_W'(sat_add(int'(err), step, ERR_LIM));
            dur <= dur + 1'b1;
         end
         if (tmo_set)
            tmo <= 1'b1;
      end
   end

`ifdef LF_LOCK_DET_EN
   localparam int LCW = $clog2(LOCK_CNT + 1);
   localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_CNT);

   logic [LCW-1:0] lock_cnt;
   logic           in_tol;

   assign in_tol = (int'(err) <= LOCK_TOL) && (int'(err) >= -LOCK_TOL);

   always_ff @(posedge clk or posedge fv_rst) begin
      if (fv_rst) begin
         lock_cnt <= '0;
      end else if (state == UPDATE) begin
         if (tmo || !in_tol)
            lock_cnt <= '0;
         else if (lock_cnt != LOCK_FULL)
            lock_cnt <= lock_cnt + 1'b1;
      end
   end

   assign locked = (lock_cnt == LOCK_FULL);
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Randomized self-checking bench for pfd_loop_filter against a pulse-level PI model.
module tb_pfd_loop_filter;

   logic       clk = 1'b0;
   logic       fv_rst = 1'b1;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic [9:0] ctrl;
   logic       ctrl_valid;
   logic       locked;

   int checks = 0;
   int failures = 0;

   pfd_loop_filter dut (
      .clk(clk), .fv_rst(fv_rst), .up(up), .dn(dn),
      .ctrl(ctrl), .ctrl_valid(ctrl_valid), .locked(locked)
   );

   always #5 clk = ~clk;

   // Strobe monitor, sampled on the falling edge.
   int         strobes = 0;
   int         consec = 0;
   logic       prev_v = 1'b0;
   always @(negedge clk) begin
      if (ctrl_valid === 1'b1) begin
         strobes++;
         if (prev_v)
            consec++;
      end
      prev_v = (ctrl_valid === 1'b1);
   end

   // Pulse-level reference model.
   int m_integ, m_ctrl, m_lock;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_reset();
      m_integ = 0;
      m_ctrl  = 512;
      m_lock  = 0;
   endtask

   task automatic model_update(input int e, input bit tmo);
      m_integ = clampi(m_integ + e, -8191, 8191);
      m_ctrl  = clampi(512 + (m_integ >>> 3) + (e >>> 1), 0, 1023);
      if (tmo || e > 2 || e < -2)
         m_lock = 0;
      else if (m_lock < 4)
         m_lock++;
   endtask

   function automatic logic exp_locked();
`ifdef LF_LOCK_DET_EN
      return (m_lock >= 4);
`else
      return 1'b0;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk);
      fv_rst = 1'b1;
      up = 1'b0;
      dn = 1'b0;
      repeat (2) @(negedge clk);
      fv_rst = 1'b0;
      model_reset();
   endtask

   // mode: 0 up only, 1 dn only, 2 both, 3 random mix (never both low mid-pulse)
   task automatic drive_pulse(input int len, input int mode, input int gap);
      int  e, n, r;
      bit  tmo, dom_up, u, d;
      e = 0; n = 0; tmo = 1'b0;
      dom_up = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         case (mode)
            0: begin u = 1; d = 0; end
            1: begin u = 0; d = 1; end
            2: begin u = 1; d = 1; end
            default: begin
               r = $urandom_range(0, 3);
               if (r < 2)       begin u = dom_up;  d = !dom_up; end
               else if (r == 2) begin u = !dom_up; d = dom_up;  end
               else             begin u = 1;       d = 1;       end
            end
         endcase
         up = u;
         dn = d;
         if (!tmo) begin
            n++;
            if (u && !d)
               e = clampi(e + 1, -127, 127);
            else if (d && !u)
               e = clampi(e - 1, -127, 127);
            if (n == 255)
               tmo = 1'b1;
         end
      end
      @(negedge clk);
      up = 1'b0;
      dn = 1'b0;
      repeat (gap) @(negedge clk);
      if (len > 0)
         model_update(e, tmo);
   endtask

   task automatic test_reset();
      do_reset();
      repeat (5) @(negedge clk);
      checks++;
      if (ctrl !== 10'd512) begin
         failures++;
         $display("FAIL reset_ctrl: got %0d expected 512", ctrl);
      end
      checks++;
      if (ctrl_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %b expected 0", ctrl_valid);
      end
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_locked: got %b expected 0", locked);
      end
   endtask

   task automatic test_up_pulse();
      int s0;
      do_reset();
      s0 = strobes;
      drive_pulse(8, 0, 8);
      checks++;
      if (ctrl !== 10'd517 || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL up_pulse_1: got ctrl=%0d strobes=%0d expected ctrl=517 strobes=1", ctrl, strobes - s0);
      end
      s0 = strobes;
      drive_pulse(8, 0, 8);
      checks++;
      if (ctrl !== 10'd518 || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL up_pulse_2: got ctrl=%0d strobes=%0d expected ctrl=518 strobes=1", ctrl, strobes - s0);
      end
   endtask

   task automatic test_dn_pulse();
      int s0;
      do_reset();
      s0 = strobes;
      drive_pulse(8, 1, 8);
      checks++;
      if (ctrl !== 10'd507 || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL dn_pulse: got ctrl=%0d strobes=%0d expected ctrl=507 strobes=1", ctrl, strobes - s0);
      end
   endtask

   task automatic test_timeout();
      int s0;
      do_reset();
      s0 = strobes;
      drive_pulse(300, 0, 8);
      checks++;
      if (ctrl !== 10'd590 || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL timeout: got ctrl=%0d strobes=%0d expected ctrl=590 strobes=1", ctrl, strobes - s0);
      end
      s0 = strobes;
      drive_pulse(8, 0, 8);
      checks++;
      if (ctrl !== m_ctrl[9:0] || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL after_timeout: got ctrl=%0d strobes=%0d expected ctrl=%0d strobes=1", ctrl, strobes - s0, m_ctrl);
      end
   endtask

   task automatic test_overlap_lock();
      int s0;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         s0 = strobes;
         drive_pulse(6, 2, 8);
         checks++;
         if (ctrl !== 10'd512 || strobes - s0 !== 1) begin
            failures++;
            $display("FAIL overlap_%0d: got ctrl=%0d strobes=%0d expected ctrl=512 strobes=1", k, ctrl, strobes - s0);
         end
         checks++;
         if (locked !== exp_locked()) begin
            failures++;
            $display("FAIL overlap_lock_%0d: got %b expected %b", k, locked, exp_locked());
         end
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      do_reset();
      drive_pulse(8, 0, 8);
      s0 = strobes;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         up = 1'b1;
      end
      #3 fv_rst = 1'b1;
      #1;
      checks++;
      if (ctrl !== 10'd512 || ctrl_valid !== 1'b0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: got ctrl=%0d valid=%b locked=%b expected 512/0/0", ctrl, ctrl_valid, locked);
      end
      repeat (10) @(negedge clk);
      up = 1'b0;
      repeat (3) @(negedge clk);
      fv_rst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      checks++;
      if (ctrl !== 10'd512 || strobes - s0 !== 0) begin
         failures++;
         $display("FAIL reset_mid_no_strobe: got ctrl=%0d strobes=%0d expected ctrl=512 strobes=0", ctrl, strobes - s0);
      end
   endtask

   task automatic test_glitch();
      int s0;
      s0 = strobes;
      @(negedge clk);
      #1 up = 1'b1;
      #2 up = 1'b0;
      repeat (8) @(negedge clk);
      checks++;
      if (strobes - s0 !== 0) begin
         failures++;
         $display("FAIL glitch_strobe: got %0d expected 0", strobes - s0);
      end
      s0 = strobes;
      drive_pulse(5, 1, 8);
      checks++;
      if (ctrl !== m_ctrl[9:0] || strobes - s0 !== 1) begin
         failures++;
         $display("FAIL glitch_recover: got ctrl=%0d strobes=%0d expected ctrl=%0d strobes=1", ctrl, strobes - s0, m_ctrl);
      end
   endtask

   task automatic test_random();
      int s0, len, mode, gap;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         len  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(4, 200);
         mode = $urandom_range(0, 3);
         gap  = $urandom_range(5, 12);
         s0   = strobes;
         drive_pulse(len, mode, gap);
         checks++;
         if (ctrl !== m_ctrl[9:0] || strobes - s0 !== 1) begin
            failures++;
            $display("FAIL random_%0d: got ctrl=%0d strobes=%0d expected ctrl=%0d strobes=1 (len=%0d mode=%0d)",
                     k, ctrl, strobes - s0, m_ctrl, len, mode);
         end
         checks++;
         if (locked !== exp_locked()) begin
            failures++;
            $display("FAIL random_lock_%0d: got %b expected %b", k, locked, exp_locked());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_up_pulse();
      test_dn_pulse();
      test_timeout();
      test_overlap_lock();
      test_reset_mid();
      test_glitch();
      test_random();
      checks++;
      if (consec !== 0) begin
         failures++;
         $display("FAIL valid_back_to_back: got %0d expected 0", consec);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pfd_loop_filter.md
# pfd_loop_filter

Digital loop filter directly downstream of the phase-frequency detector. It oversamples the PFD `up`/`dn` pulses on a fast sampling clock and measures each pulse pair as a signed phase error. A proportional-integral update turns that error into a clamped DCO control word. An optional lock detector flags stable operation.

## Interface
Parameters:
- `CTRL_W`, 10: control word width (unsigned).
- `CNT_W`, 8: pulse-duration counter width; signed error width is also `CNT_W`.
- `CTRL_INIT`, 512: control word after reset and integrator zero point.
- `KP_SHIFT`, 1: proportional gain, as an arithmetic right shift of the error.
- `KI_SHIFT`, 3: integral gain, as an arithmetic right shift of the integrator.
- `LOCK_TOL`, 2: maximum |err| that counts as in lock.
- `LOCK_CNT`, 4: number of consecutive in-tolerance updates needed to assert `locked`.

Ports:
- `clk` in 1: sampling clock, at least 16× the reference frequency.
- `fv_rst` in 1: reset, asynchronous, active-high.
- `up` in 1: PFD up pulse, asynchronous to `clk`.
- `dn` in 1: PFD down pulse, asynchronous to `clk`.
- `ctrl` out `CTRL_W`: DCO control word.
- `ctrl_valid` out 1: one-cycle strobe when `ctrl` updates.
- `locked` out 1: lock indication.

## Operation
- `up` and `dn` each pass through a 2-flop synchronizer, giving `up_s` and `dn_s`.
- State machine states: `IDLE`, `MEASURE`, `UPDATE`, `DRAIN`.
  - `IDLE` → `MEASURE` when `up_s` or `dn_s` is high. The error accumulation starts in this same cycle.
  - In `MEASURE`, each cycle:
    - `up_s & ~dn_s` adds +1 to `err`.
    - `dn_s & ~up_s` adds −1 to `err`.
    - Both high (PFD reset overlap) or both low adds 0.
  - `err` saturates at ±(2^(CNT_W−1)−1).
  - `dur` counts every `MEASURE` cycle.
  - `MEASURE` → `UPDATE` when `up_s` and `dn_s` are both low.
  - `MEASURE` → `UPDATE` also when `dur` reaches 2^CNT_W−1 (timeout); the state after that `UPDATE` is `DRAIN`.
  - `UPDATE` is exactly one cycle and always performs the update. It then goes to `IDLE`, or to `DRAIN` after a timeout.
  - `DRAIN` → `IDLE` once `up_s` and `dn_s` are both low. No measurement happens in `DRAIN`.
- Update arithmetic, done in `UPDATE`:
  - Integrator: `integ += err`. `integ` is signed, `CTRL_W+KI_SHIFT+1` bits wide, and saturating.
  - Output: `ctrl = clamp(CTRL_INIT + (integ >>> KI_SHIFT) + (err >>> KP_SHIFT), 0, 2^CTRL_W−1)`.
  - `ctrl_valid` is asserted for this cycle.
  - `err` and `dur` are cleared.
- Sign convention: `up` means the reference leads, so `ctrl` increases.

## Timing
- Reset values: `ctrl`=`CTRL_INIT`, `ctrl_valid`=0, `locked`=0. Internally `integ`=0, `err`=0, `dur`=0, state `IDLE`, synchronizers 0.
- Latency:
  - From an input edge to the first cycle counted: 2 `clk` cycles (synchronizer).
  - From both inputs seen low at the synchronizer outputs to `ctrl`/`ctrl_valid` registered: 2 cycles (the `MEASURE`→`UPDATE` transition, then the registered output).
- `ctrl` is held between strobes. `ctrl_valid` is never high on two consecutive cycles.
- `fv_rst` asserted mid-`MEASURE` aborts the measurement immediately. No `ctrl_valid` is emitted and every register returns to its reset value.
- A pulse shorter than one `clk` period may be missed. This is acceptable and must not hang the state machine.

## Configuration
- `LF_LOCK_DET_EN` defined:
  - A lock counter increments on each `UPDATE` where |err| ≤ `LOCK_TOL`.
  - The counter clears on any `UPDATE` with |err| > `LOCK_TOL`, and on every timeout.
  - `locked` is asserted once the counter reaches `LOCK_CNT`.
  - `locked` deasserts in the cycle after the first out-of-tolerance update.
- `LF_LOCK_DET_EN` undefined: no lock counter logic exists and `locked` is tied to 0.

## Structure
- Shared package `pll_pkg`:
  - state enum type `lf_state_t`
  - default widths and gains `CTRL_W`, `CNT_W`, `CTRL_INIT`, `KP_SHIFT`, `KI_SHIFT`
  - a `sat_add` function
- One sub-module, `lf_sync`: the 2-flop synchronizer, instantiated once per input and reset by `fv_rst`.

## Test plan
All scenarios use default parameters.
- Reset release, no pulses → `ctrl`=512, `ctrl_valid`=0, `locked`=0.
- One `up` pulse, 8 cycles, `dn` low → err=+8, integ=8, `ctrl`=512+1+4=517, one `ctrl_valid` strobe. A second identical pulse → `ctrl`=518.
- From reset, one `dn` pulse, 8 cycles → `ctrl`=512−1−4=507.
- `up` held high for 300 cycles → timeout after 255 cycles with err=+127 and `ctrl`=512+15+63=590. No further strobe until `up` falls and a new pulse arrives.
- `up` and `dn` high together for 6 cycles → err=0, `ctrl` unchanged, strobe still emitted. With `LF_LOCK_DET_EN`, `locked` rises after the 4th such pair.
- `fv_rst` pulsed during a 20-cycle `up` pulse → no strobe, and `ctrl` returns to 512 asynchronously.
